// File: rtl/r4_divider_odd.sv
// ---------------------------------------------------------------------------
// r4_divider_odd
//
// Iterative radix-4 unsigned restoring divider. Retires two quotient bits per
// falling clock edge. Odd operand widths are zero-padded to the next even
// width, so a division takes K = ceil(N/2) iterations.
//
// Ports
//   clkn_i       clock, all flops update on the falling edge
//   rstn_i       asynchronous active-low reset
//   start_i      request, sampled only while busy_o = 0
//   dividend_i   N-bit unsigned dividend, sampled with start_i
//   divisor_i    N-bit unsigned divisor, sampled with start_i
//   busy_o       high while iterating
//   done_o       single-cycle result-valid pulse
//   quotient_o   N-bit quotient, held until the next result
//   remainder_o  N-bit remainder, held until the next result
//   dbz_o        divide-by-zero flag for the held result
// ---------------------------------------------------------------------------
module r4_divider_odd #(
  parameter int N = 13
) (
  input  logic         clkn_i,
  input  logic         rstn_i,
  input  logic         start_i,
  input  logic [N-1:0] dividend_i,
  input  logic [N-1:0] divisor_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] quotient_o,
  output logic [N-1:0] remainder_o,
  output logic         dbz_o
);

  localparam int P  = N + (N % 2);   // padded (even) width
  localparam int K  = P / 2;         // iterations per division
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [N+1:0]    rem_q,   rem_d;   // partial remainder
  logic [P-1:0]    dvd_q,   dvd_d;   // dividend, shifted out MSB-first
  logic [N-1:0]    dvs_q,   dvs_d;   // latched divisor
  logic [P-1:0]    quo_q,   quo_d;   // quotient being assembled
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [N-1:0]    quot_q,  quot_d;
  logic [N-1:0]    rmd_q,   rmd_d;
  logic            dbz_q,   dbz_d;

  // Datapath for one radix-4 step. The partial remainder is always below the
  // divisor, so its low N bits plus the two incoming dividend bits form the
  // full trial value t < 4D, which fits in N+2 bits.
  logic [N+1:0] trial;
  logic [N+1:0] mul1, mul2, mul3;
  logic [N+1:0] rem_nxt;
  logic [1:0]   digit;
  logic [P-1:0] quo_nxt;

  always_comb begin
    trial = {rem_q[N-1:0], dvd_q[P-1 -: 2]};
    mul1  = {2'b00, dvs_q};
    mul2  = {1'b0, dvs_q, 1'b0};
    mul3  = mul1 + mul2;
    if (trial >= mul3) begin
      digit   = 2'd3;
      rem_nxt = trial - mul3;
    end else if (trial >= mul2) begin
      digit   = 2'd2;
      rem_nxt = trial - mul2;
    end else if (trial >= mul1) begin
      digit   = 2'd1;
      rem_nxt = trial - mul1;
    end else begin
      digit   = 2'd0;
      rem_nxt = trial;
    end
    quo_nxt = {quo_q[P-3:0], digit};
  end

  // The top remainder bits are provably zero and the padded quotient MSB is
  // always zero; they are kept only for width symmetry.
  logic unused_bits;
  assign unused_bits = ^{rem_q[N+1:N], quo_nxt[P-1]};

  always_comb begin
    // NOTE: every _d takes its _q value first, so no path leaves a signal
    // unassigned and no latch is inferred.
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start_i) begin
          if (divisor_i == '0) begin
            // Divide by zero resolves immediately without iterating.
            quot_d  = '1;
            rmd_d   = dividend_i;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dvd_d   = P'(dividend_i);
            dvs_d   = divisor_i;
            rem_d   = '0;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        dvd_d = {dvd_q[P-3:0], 2'b00};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) begin
          quot_d  = quo_nxt[N-1:0];
          rmd_d   = rem_nxt[N-1:0];
          dbz_d   = 1'b0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, including the operand and result holding
  // registers, is cleared by reset so an aborted division leaves no residue.
  always_ff @(negedge clkn_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops see pre-edge values.
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o      = (state_q == S_CALC);
  assign done_o      = (state_q == S_DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = rmd_q;
  assign dbz_o       = dbz_q;

endmodule

// File: doc/r4_divider_odd.md
# r4_divider_odd

Iterative radix-4 unsigned integer divider: the inverse of the team's radix-4 Booth multiplier. It takes an N-bit dividend and an N-bit divisor and returns the N-bit quotient and N-bit remainder, retiring two quotient bits per cycle. It sits beside the multiplier in the nonlinear-approximation datapath, for normalisation and reciprocal-seed stages. It uses a start/busy/done handshake.

## Interface
- N, default 13, operand width. Any N ≥ 3 is legal; odd N is zero-padded internally to N+1 bits.
- clkn_i  in  1  clock; all flops update on the falling edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- start_i  in  1  request; sampled only when busy_o=0.
- dividend_i  in  N  unsigned dividend; sampled together with start_i.
- divisor_i  in  N  unsigned divisor; sampled together with start_i.
- busy_o  out  1  high while in CALC state.
- done_o  out  1  single-cycle result-valid pulse.
- quotient_o  out  N  unsigned quotient; holds until the next result.
- remainder_o  out  N  unsigned remainder; holds until the next result.
- dbz_o  out  1  divide-by-zero flag for the current result; holds with the result.

## Operation
- Internal widths:
  - padded width P = N rounded up to even (14 for N=13).
  - iteration count K = P/2 (7).
  - partial remainder is N+2 bits.
  - 2D and 3D multiples are N+2 bits, zero-extended.
- States:
  - IDLE: busy_o=0, done_o=0.
  - CALC: busy_o=1.
  - DONE: busy_o=0, done_o=1, lasts exactly one cycle.
- IDLE or DONE, start_i=1, divisor_i≠0:
  - latch the operands.
  - clear the remainder and the iteration counter.
  - go to CALC.
- IDLE or DONE, start_i=1, divisor_i=0:
  - quotient_o = all ones, remainder_o = dividend_i, dbz_o=1.
  - go to DONE.
- DONE, start_i=0: go to IDLE.
- CALC iteration:
  - form t = {rem, next two dividend bits, MSB first}.
  - compare t against 3D, 2D and D.
  - digit q = largest of 3, 2, 1, 0 with q·D ≤ t.
  - rem ← t − q·D; shift q into the quotient register.
  - increment the counter.
- Leaving CALC: after iteration K the final quotient (low N bits) and remainder are written to the outputs, dbz_o←0, and the state moves to DONE. The padded quotient MSB is always 0 and is discarded.
- start_i while busy_o=1 is ignored; latched operands are unaffected.
- quotient_o, remainder_o and dbz_o change only when entering DONE; they are stable otherwise.
- Reset, including mid-CALC:
  - state IDLE; all outputs and internal registers 0.
  - the aborted operation never produces done_o.

## Timing
- Edge 0: falling edge that samples start_i=1.
- Normal division:
  - CALC runs during edges 1..K.
  - edge K updates the outputs and raises done_o.
  - edge K+1 lowers done_o.
  - latency start→done = K falling edges (7 for N=13).
- Divide-by-zero: outputs and done_o are updated at edge 0 (latency 0 edges after sampling, visible 1 cycle later).
- Back-to-back: start_i=1 during the DONE cycle is accepted at edge K+1. Peak throughput is one division per K+1 cycles.
- busy_o is high from after edge 0 until after edge K.

## Test plan
- Reset: rstn_i=0 → all outputs 0. Release, idle 5 cycles → done_o never asserts.
- Basic: 100/7 → done_o after 7 edges; quotient 14, remainder 2, dbz_o 0. Also 0/3 → 0, 0.
- Extremes (N=13):
  - 8191/1 → 8191, 0.
  - 8191/8191 → 1, 0.
  - 4096/8191 → 0, 4096.
  - 8191/3 → 2730, 1 (exercises the 3D path).
- Divide by zero: 5/0 → done_o 1 cycle after the sampling edge; quotient 8191, remainder 5, dbz_o 1. A following 9/4 gives 2, 1 with dbz_o 0.
- Handshake:
  - start 50/6 → 8, 2.
  - start_i=1 with 77/5 at edge 3 → ignored.
  - start 77/5 in the DONE cycle → accepted back-to-back, gives 15, 2.
- Reset mid-CALC, then random: assert rstn_i at edge 4 → outputs 0, no done_o. Then 10k random operands (including 0 divisors) are checked against a reference model for quotient, remainder, dbz_o and exact latency.
